// File: rtl/fft_addr_gen.sv
// Radix-2 DIF in-place FFT address sequencer: walks all stages/butterflies and emits
// (addr_a, addr_b, tw_addr) per butterfly with valid/ready flow control and inter-stage gaps.
module fft_addr_gen #(
  parameter int LOG2N     = 5,
  parameter int STAGE_GAP = 0,
  localparam int SW       = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic [SW-1:0]    stage,
  output logic             stage_last,
  output logic             fft_last,
  output logic             done
);

  localparam int N         = 1 << LOG2N;
  localparam int BW        = LOG2N - 1;
  localparam int HALF_LAST = (N / 2) - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t          r_state, w_state;
  logic [SW-1:0]   r_s, w_s;
  logic [BW-1:0]   r_b, w_b;
  logic [3:0]      r_gap, w_gap;
  logic            w_done;
  logic            w_xfer;
  logic [LOG2N-1:0] w_a, w_bb;
  logic [BW-1:0]   w_tw;
  logic            w_sl, w_fl;

  logic            r_busy, r_valid, r_done, r_sl, r_fl;
  logic [LOG2N-1:0] r_addr_a, r_addr_b;
  logic [BW-1:0]   r_tw;
  logic [SW-1:0]   r_stage;

  assign w_xfer = (r_state == S_RUN) && out_ready;

  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_b     = r_b;
    w_gap   = r_gap;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_RUN;
          w_s     = '0;
          w_b     = '0;
        end
      end
      S_RUN: begin
        if (w_xfer) begin
          if (r_b != BW'(HALF_LAST)) begin
            w_b = r_b + 1'b1;
          end else if (r_s != SW'(LOG2N - 1)) begin
            w_b = '0;
            w_s = r_s + 1'b1;
            if (STAGE_GAP > 0) begin
              w_state = S_GAP;
              w_gap   = 4'(STAGE_GAP - 1);
            end
          end else begin
            w_state = S_IDLE;
            w_s     = '0;
            w_b     = '0;
            w_done  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state = S_RUN;
        else             w_gap   = r_gap - 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Address triple is computed from next (s,b) so the registered outputs track the state
  // registers; during a stall next == current, which holds every output stable.
  always_comb begin
    int unsigned si, bi, span, j, g;
    si   = 32'(w_s);
    bi   = 32'(w_b);
    span = 32'(N) >> (si + 1);
    j    = bi & (span - 1);
    g    = bi >> (32'(LOG2N) - 1 - si);
    w_a  = LOG2N'(g * 2 * span + j);
    w_bb = LOG2N'(g * 2 * span + j + span);
    w_tw = BW'(j << si);
    w_sl = (w_state == S_RUN) && (w_b == BW'(HALF_LAST));
    w_fl = w_sl && (w_s == SW'(LOG2N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_s      <= '0;
      r_b      <= '0;
      r_gap    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_sl     <= 1'b0;
      r_fl     <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_tw     <= '0;
      r_stage  <= '0;
    end else begin
      r_state  <= w_state;
      r_s      <= w_s;
      r_b      <= w_b;
      r_gap    <= w_gap;
      r_busy   <= (w_state != S_IDLE);
      r_valid  <= (w_state == S_RUN);
      r_done   <= w_done;
      r_sl     <= w_sl;
      r_fl     <= w_fl;
      r_addr_a <= w_a;
      r_addr_b <= w_bb;
      r_tw     <= w_tw;
      r_stage  <= w_s;
    end
  end

  assign busy       = r_busy;
  assign out_valid  = r_valid;
  assign done       = r_done;
  assign stage_last = r_sl;
  assign fft_last   = r_fl;
  assign addr_a     = r_addr_a;
  assign addr_b     = r_addr_b;
  assign tw_addr    = r_tw;
  assign stage      = r_stage;

endmodule
